cpu_m_reg: RTL and testbench

//   Status-flag register for the one-cycle CPU. Holds the ALU condition flags

---
 rtl/cpu_m_reg.sv | 57 +++++
 tb/tb_cpu_m_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_m_reg.sv
// Condition-flag register (carry, zero, borrow) sitting between the ALU and the
// branch logic. C and B update only when enabled; Z follows the ALU every cycle.
module cpu_m_reg (
    input  logic CLK,
    input  logic RST,
    input  logic EN_C,
    input  logic EN_B,
    input  logic Cin,
    input  logic Zin,
    input  logic Bin,
    output logic C,
    output logic Z,
    output logic B
);

    logic c_d;
    logic c_q;
    logic z_d;
    logic z_q;
    logic b_d;
    logic b_q;

    // Next-state selection for each flag
    always_comb begin
        c_d = c_q;
        b_d = b_q;
        z_d = Zin;
        if (EN_C) begin
            c_d = Cin;
        end else begin
            c_d = c_q;
        end
        if (EN_B) begin
            b_d = Bin;
        end else begin
            b_d = b_q;
        end
    end

    // Flag storage; RST low clears all flags without waiting for a clock edge
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
            b_q <= 1'b0;
        end else begin
            c_q <= c_d;
            z_q <= z_d;
            b_q <= b_d;
        end
    end

    assign C = c_q;
    assign Z = z_q;
    assign B = b_q;

endmodule

// File: tb/tb_cpu_m_reg.sv
// Bench for cpu_m_reg: a directed vector table, hand-written async-reset and
// glitch sequences, then random traffic compared against a flag model.
module tb_cpu_m_reg;

    logic CLK;
    logic RST;
    logic EN_C;
    logic EN_B;
    logic Cin;
    logic Zin;
    logic Bin;
    logic C;
    logic Z;
    logic B;

    int checks;
    int errors;

    // Reference flag state, updated from the behavioural rules
    logic m_c;
    logic m_z;
    logic m_b;

    typedef struct {
        logic rst;
        logic en_c;
        logic en_b;
        logic cin;
        logic zin;
        logic bin;
        logic exp_c;
        logic exp_z;
        logic exp_b;
    } vec_t;

    vec_t tbl[16];

    cpu_m_reg dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN_C (EN_C),
        .EN_B (EN_B),
        .Cin  (Cin),
        .Zin  (Zin),
        .Bin  (Bin),
        .C    (C),
        .Z    (Z),
        .B    (B)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: CZB got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, sample after the rising edge
    task automatic step(input logic rst, input logic en_c, input logic en_b,
                        input logic cin, input logic zin, input logic bin);
        @(negedge CLK);
        RST  = rst;
        EN_C = en_c;
        EN_B = en_b;
        Cin  = cin;
        Zin  = zin;
        Bin  = bin;
        @(posedge CLK);
        #1;
        if (!rst) begin
            m_c = 1'b0;
            m_z = 1'b0;
            m_b = 1'b0;
        end else begin
            if (en_c) m_c = cin;
            if (en_b) m_b = bin;
            m_z = zin;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_c = 1'b0;
        m_z = 1'b0;
        m_b = 1'b0;
        RST = 1'b0;
        EN_C = 1'b0;
        EN_B = 1'b0;
        Cin = 1'b0;
        Zin = 1'b0;
        Bin = 1'b0;

        //             rst   en_c  en_b  cin   zin   bin   C     Z     B
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        // Held in reset with busy inputs: flags must stay clear
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk("hold_reset", {C, Z, B}, 3'b000);
        end

        // Reset release by itself must not move any flag
        @(negedge CLK);
        EN_C = 1'b0;
        Cin  = 1'b1;
        RST  = 1'b1;
        #1;
        chk("release", {C, Z, B}, 3'b000);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].en_c, tbl[i].en_b, tbl[i].cin, tbl[i].zin, tbl[i].bin);
            chk($sformatf("table_%0d", i), {C, Z, B}, {tbl[i].exp_c, tbl[i].exp_z, tbl[i].exp_b});
        end

        // Asynchronous clear mid-cycle with all flags set and enables high
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("all_set", {C, Z, B}, 3'b111);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk("async_clear", {C, Z, B}, 3'b000);
        @(posedge CLK);
        #1;
        chk("clear_held", {C, Z, B}, 3'b000);
        m_c = 1'b0;
        m_z = 1'b0;
        m_b = 1'b0;

        // Input changes between edges must not reach the outputs
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("glitch_setup", {C, Z, B}, 3'b100);
        @(negedge CLK);
        EN_C = 1'b1;
        Cin  = 1'b0;
        Zin  = 1'b1;
        EN_B = 1'b1;
        Bin  = 1'b1;
        #1;
        chk("glitch_mid", {C, Z, B}, 3'b100);
        Cin  = 1'b1;
        Zin  = 1'b0;
        Bin  = 1'b0;
        @(posedge CLK);
        #1;
        chk("glitch_after", {C, Z, B}, 3'b100);
        m_c = 1'b1;
        m_z = 1'b0;
        m_b = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(15, 0) != 0) ? 1'b1 : 1'b0,
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk("random", {C, Z, B}, {m_c, m_z, m_b});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
